// File: rtl/date_counter_pkg.sv
// Shared constants for the calendar counter: FSM states, set-field codes,
// month markers and the year limit.
package date_counter_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET   = 2'd1,
        ST_CLAMP = 2'd2
    } state_e;

    localparam logic [1:0] FLD_NONE  = 2'd0;
    localparam logic [1:0] FLD_DAY   = 2'd1;
    localparam logic [1:0] FLD_MONTH = 2'd2;
    localparam logic [1:0] FLD_YEAR  = 2'd3;

    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] DEC = 4'd12;

    localparam logic [6:0] YEAR_MAX = 7'd99;

endpackage

// File: rtl/date_counter_month_length.sv
// Days in a month for the given month number and leap flag.
// Purely combinational.
module month_length
    import date_counter_pkg::*;
(
    input  logic [3:0] MONTH,
    input  logic       LEAP,
    output logic [4:0] DIM
);

    always_comb begin
        DIM = 5'd31;
        case (MONTH)
            FEB:                       DIM = LEAP ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   DIM = 5'd30;
            default:                   DIM = 5'd31;
        endcase
    end

endmodule

// File: rtl/date_counter.sv
// Calendar counter: advances one day per DAY_TICK with month/year/century
// rollover, and lets each field be set manually through a SET/CLAMP FSM.
module date_counter
    import date_counter_pkg::*;
#(
    parameter logic [6:0] RESET_YEAR  = 7'd20,
    parameter logic [3:0] RESET_MONTH = 4'd1,
    parameter logic [4:0] RESET_DAY   = 5'd1
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       DAY_TICK,
    input  logic       SET_EN,
    input  logic [1:0] SET_FIELD,
    input  logic       INC,
    output logic [6:0] YEAR,
    output logic [3:0] MONTH,
    output logic [4:0] DAY,
    output logic       LEAP,
    output logic       CENTURY,
    output logic [1:0] STATE_DBG
);

    state_e     state_q, state_d;
    logic [6:0] year_q, year_d;
    logic [3:0] month_q, month_d;
    logic [4:0] day_q, day_d;
    logic       century_q, century_d;
    logic       pend_q, pend_d;
    logic [4:0] dim;

    assign LEAP = (year_q[1:0] == 2'b00);

    // Single month-length table shared by rollover, set-wrap and clamp.
    month_length u_month_length (
        .MONTH (month_q),
        .LEAP  (LEAP),
        .DIM   (dim)
    );

    always_comb begin
        state_d   = state_q;
        year_d    = year_q;
        month_d   = month_q;
        day_d     = day_q;
        century_d = 1'b0;
        pend_d    = pend_q;

        case (state_q)
            ST_RUN: begin
                // A pending tick is only ever set outside RUN, so it is
                // consumed here on the first RUN cycle and merges with a real tick.
                pend_d = 1'b0;
                if (DAY_TICK || pend_q) begin
                    if (day_q < dim) begin
                        day_d = day_q + 5'd1;
                    end else begin
                        day_d = 5'd1;
                        if (month_q == DEC) begin
                            month_d = 4'd1;
                            if (year_q == YEAR_MAX) begin
                                year_d    = 7'd0;
                                century_d = 1'b1;
                            end else begin
                                year_d = year_q + 7'd1;
                            end
                        end else begin
                            month_d = month_q + 4'd1;
                        end
                    end
                end
                if (SET_EN) state_d = ST_SET;
            end

            ST_SET: begin
                if (DAY_TICK) pend_d = 1'b1;
                if (INC) begin
                    case (SET_FIELD)
                        FLD_DAY:   day_d   = (day_q >= dim)      ? 5'd1 : day_q + 5'd1;
                        FLD_MONTH: month_d = (month_q >= DEC)    ? 4'd1 : month_q + 4'd1;
                        FLD_YEAR:  year_d  = (year_q >= YEAR_MAX) ? 7'd0 : year_q + 7'd1;
                        default:   ;
                    endcase
                end
                if (!SET_EN) state_d = ST_CLAMP;
            end

            ST_CLAMP: begin
                if (DAY_TICK) pend_d = 1'b1;
                if (day_q > dim) day_d = dim;
                state_d = ST_RUN;
            end

            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= ST_RUN;
            year_q    <= RESET_YEAR;
            month_q   <= RESET_MONTH;
            day_q     <= RESET_DAY;
            century_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            year_q    <= year_d;
            month_q   <= month_d;
            day_q     <= day_d;
            century_q <= century_d;
            pend_q    <= pend_d;
        end
    end

    assign YEAR      = year_q;
    assign MONTH     = month_q;
    assign DAY       = day_q;
    assign CENTURY   = century_q;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_date_counter.sv
// Directed-vector bench for date_counter: a table of per-cycle inputs with
// hand-computed expected outputs, plus hand-written reset sequences.
module tb_date_counter;
    import date_counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       day_tick = 1'b0;
    logic       set_en = 1'b0;
    logic [1:0] set_field = 2'd0;
    logic       inc = 1'b0;
    logic [6:0] year;
    logic [3:0] month;
    logic [4:0] day;
    logic       leap;
    logic       century;
    logic [1:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;

    date_counter dut (
        .CLK       (clk),
        .RESETN    (rst_n),
        .DAY_TICK  (day_tick),
        .SET_EN    (set_en),
        .SET_FIELD (set_field),
        .INC       (inc),
        .YEAR      (year),
        .MONTH     (month),
        .DAY       (day),
        .LEAP      (leap),
        .CENTURY   (century),
        .STATE_DBG (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic reset_dut();
        @(negedge clk);
        day_tick = 1'b0; set_en = 1'b0; set_field = 2'd0; inc = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [6:0] ey, input logic [3:0] em,
                         input logic [4:0] ed, input logic ec, input logic [1:0] est);
        logic el;
        el = (ey % 4 == 0);
        n_vec++;
        if (year !== ey || month !== em || day !== ed || century !== ec ||
            state_dbg !== est || leap !== el) begin
            n_err++;
            $display("FAIL %s: got %0d-%0d-%0d c=%0d st=%0d leap=%0d, expected %0d-%0d-%0d c=%0d st=%0d leap=%0d",
                     name, year, month, day, century, state_dbg, leap,
                     ey, em, ed, ec, est, el);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic cycle(input logic tk, input logic se, input logic [1:0] fld, input logic in);
        @(negedge clk);
        day_tick = tk; set_en = se; set_field = fld; inc = in;
        @(posedge clk);
        #1;
    endtask

    // From reset (20-01-01): set day while in January, then month, then year.
    task automatic load_date(input string name, input int ty, input int tm, input int td);
        reset_dut();
        cycle(1'b0, 1'b1, FLD_NONE, 1'b0);
        for (int i = 0; i < td - 1; i++) cycle(1'b0, 1'b1, FLD_DAY, 1'b1);
        for (int i = 0; i < tm - 1; i++) cycle(1'b0, 1'b1, FLD_MONTH, 1'b1);
        for (int i = 0; i < (ty + 80) % 100; i++) cycle(1'b0, 1'b1, FLD_YEAR, 1'b1);
        cycle(1'b0, 1'b0, FLD_NONE, 1'b0);
        cycle(1'b0, 1'b0, FLD_NONE, 1'b0);
        check(name, 7'(ty), 4'(tm), 5'(td), 1'b0, ST_RUN);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       load;
        logic       tk;
        logic       se;
        logic [1:0] fld;
        logic       in;
        int         y;
        int         m;
        int         d;
        logic       c;
        logic [1:0] st;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic void ld(input string n, input int y, input int m, input int d);
        vec_t v;
        v.load = 1'b1; v.tk = 1'b0; v.se = 1'b0; v.fld = 2'd0; v.in = 1'b0;
        v.y = y; v.m = m; v.d = d; v.c = 1'b0; v.st = ST_RUN; v.name = n;
        vecs.push_back(v);
    endfunction

    function automatic void cy(input string n, input logic tk, input logic se, input logic [1:0] fld,
                               input logic in, input int y, input int m, input int d,
                               input logic c, input logic [1:0] st);
        vec_t v;
        v.load = 1'b0; v.tk = tk; v.se = se; v.fld = fld; v.in = in;
        v.y = y; v.m = m; v.d = d; v.c = c; v.st = st; v.name = n;
        vecs.push_back(v);
    endfunction

    initial begin
        // Leap February
        ld("load_20_02_28", 20, 2, 28);
        cy("leap_tick1", 1, 0, FLD_NONE, 0, 20, 2, 29, 0, ST_RUN);
        cy("leap_tick2", 1, 0, FLD_NONE, 0, 20, 3, 1, 0, ST_RUN);
        // Non-leap February
        ld("load_21_02_28", 21, 2, 28);
        cy("nonleap_tick", 1, 0, FLD_NONE, 0, 21, 3, 1, 0, ST_RUN);
        // Natural century wrap
        ld("load_99_12_31", 99, 12, 31);
        cy("century_tick", 1, 0, FLD_NONE, 0, 0, 1, 1, 1, ST_RUN);
        cy("century_drop", 0, 0, FLD_NONE, 0, 0, 1, 1, 0, ST_RUN);
        cy("after_wrap_tick", 1, 0, FLD_NONE, 0, 0, 1, 2, 0, ST_RUN);
        // Set-mode year wrap gives no century pulse
        ld("load_99_05_05", 99, 5, 5);
        cy("enter_set", 0, 1, FLD_NONE, 0, 99, 5, 5, 0, ST_SET);
        cy("set_year_wrap", 0, 1, FLD_YEAR, 1, 0, 5, 5, 0, ST_SET);
        cy("exit_set_yw", 0, 0, FLD_NONE, 0, 0, 5, 5, 0, ST_CLAMP);
        cy("run_yw", 0, 0, FLD_NONE, 0, 0, 5, 5, 0, ST_RUN);
        // Clamp to 28 in non-leap year
        ld("load_20_01_31", 20, 1, 31);
        cy("clamp_enter", 0, 1, FLD_NONE, 0, 20, 1, 31, 0, ST_SET);
        cy("clamp_mon", 0, 1, FLD_MONTH, 1, 20, 2, 31, 0, ST_SET);
        cy("clamp_yr", 0, 1, FLD_YEAR, 1, 21, 2, 31, 0, ST_SET);
        cy("clamp_exit", 0, 0, FLD_NONE, 0, 21, 2, 31, 0, ST_CLAMP);
        cy("clamp_28", 0, 0, FLD_NONE, 0, 21, 2, 28, 0, ST_RUN);
        // Clamp to 29 in leap year
        ld("load_24_01_31", 24, 1, 31);
        cy("clamp24_enter", 0, 1, FLD_NONE, 0, 24, 1, 31, 0, ST_SET);
        cy("clamp24_mon", 0, 1, FLD_MONTH, 1, 24, 2, 31, 0, ST_SET);
        cy("clamp24_exit", 0, 0, FLD_NONE, 0, 24, 2, 31, 0, ST_CLAMP);
        cy("clamp_29", 0, 0, FLD_NONE, 0, 24, 2, 29, 0, ST_RUN);
        // Three ticks in SET collapse to one advance, applied a cycle after CLAMP
        ld("load_20_05_10", 20, 5, 10);
        cy("pend_enter", 0, 1, FLD_NONE, 0, 20, 5, 10, 0, ST_SET);
        cy("pend_t1", 1, 1, FLD_NONE, 0, 20, 5, 10, 0, ST_SET);
        cy("pend_t2", 1, 1, FLD_NONE, 0, 20, 5, 10, 0, ST_SET);
        cy("pend_t3", 1, 1, FLD_NONE, 0, 20, 5, 10, 0, ST_SET);
        cy("pend_exit", 0, 0, FLD_NONE, 0, 20, 5, 10, 0, ST_CLAMP);
        cy("pend_clamp", 0, 0, FLD_NONE, 0, 20, 5, 10, 0, ST_RUN);
        cy("pend_apply", 0, 0, FLD_NONE, 0, 20, 5, 11, 0, ST_RUN);
        cy("pend_once", 0, 0, FLD_NONE, 0, 20, 5, 11, 0, ST_RUN);
        // Tick during CLAMP becomes pending
        ld("load_20_06_10", 20, 6, 10);
        cy("ctick_enter", 0, 1, FLD_NONE, 0, 20, 6, 10, 0, ST_SET);
        cy("ctick_exit", 0, 0, FLD_NONE, 0, 20, 6, 10, 0, ST_CLAMP);
        cy("ctick_clamp", 1, 0, FLD_NONE, 0, 20, 6, 10, 0, ST_RUN);
        cy("ctick_apply", 0, 0, FLD_NONE, 0, 20, 6, 11, 0, ST_RUN);
        // Pending flag merges with a real tick in the first RUN cycle
        ld("load_20_07_10", 20, 7, 10);
        cy("merge_enter", 0, 1, FLD_NONE, 0, 20, 7, 10, 0, ST_SET);
        cy("merge_tset", 1, 1, FLD_NONE, 0, 20, 7, 10, 0, ST_SET);
        cy("merge_exit", 0, 0, FLD_NONE, 0, 20, 7, 10, 0, ST_CLAMP);
        cy("merge_clamp", 0, 0, FLD_NONE, 0, 20, 7, 10, 0, ST_RUN);
        cy("merge_tick", 1, 0, FLD_NONE, 0, 20, 7, 11, 0, ST_RUN);
        cy("merge_idle", 0, 0, FLD_NONE, 0, 20, 7, 11, 0, ST_RUN);
        // Tick together with SET_EN rising at month end
        ld("load_20_01_31b", 20, 1, 31);
        cy("tick_with_set", 1, 1, FLD_NONE, 0, 20, 2, 1, 0, ST_SET);
        cy("tws_exit", 0, 0, FLD_NONE, 0, 20, 2, 1, 0, ST_CLAMP);
        cy("tws_run", 0, 0, FLD_NONE, 0, 20, 2, 1, 0, ST_RUN);
        // INC together with SET_EN falling
        ld("load_20_03_15", 20, 3, 15);
        cy("incfall_enter", 0, 1, FLD_NONE, 0, 20, 3, 15, 0, ST_SET);
        cy("inc_with_exit", 0, 0, FLD_MONTH, 1, 20, 4, 15, 0, ST_CLAMP);
        cy("incfall_run", 0, 0, FLD_NONE, 0, 20, 4, 15, 0, ST_RUN);
        cy("inc_ignored_run", 0, 0, FLD_DAY, 1, 20, 4, 15, 0, ST_RUN);
        // Set-mode day wrap, no-field INC, month wrap without year carry
        ld("load_20_04_30", 20, 4, 30);
        cy("dwrap_enter", 0, 1, FLD_NONE, 0, 20, 4, 30, 0, ST_SET);
        cy("set_day_wrap", 0, 1, FLD_DAY, 1, 20, 4, 1, 0, ST_SET);
        cy("set_fld_none", 0, 1, FLD_NONE, 1, 20, 4, 1, 0, ST_SET);
        ld("load_20_12_05", 20, 12, 5);
        cy("mwrap_enter", 0, 1, FLD_NONE, 0, 20, 12, 5, 0, ST_SET);
        cy("set_month_wrap", 0, 1, FLD_MONTH, 1, 20, 1, 5, 0, ST_SET);
        cy("dec_tick_exit", 0, 0, FLD_NONE, 0, 20, 1, 5, 0, ST_CLAMP);
        // Natural Dec 31 -> Jan 1 with ordinary year carry
        ld("load_23_12_31", 23, 12, 31);
        cy("year_carry", 1, 0, FLD_NONE, 0, 24, 1, 1, 0, ST_RUN);

        // ---------------- run ----------------
        reset_dut();
        check("reset_state", 7'd20, 4'd1, 5'd1, 1'b0, ST_RUN);

        foreach (vecs[i]) begin
            if (vecs[i].load) begin
                load_date(vecs[i].name, vecs[i].y, vecs[i].m, vecs[i].d);
            end else begin
                cycle(vecs[i].tk, vecs[i].se, vecs[i].fld, vecs[i].in);
                check(vecs[i].name, 7'(vecs[i].y), 4'(vecs[i].m), 5'(vecs[i].d),
                      vecs[i].c, vecs[i].st);
            end
        end

        // Asynchronous reset mid-tick in RUN: takes effect before any clock edge.
        load_date("load_21_06_15", 21, 6, 15);
        @(negedge clk);
        day_tick = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("async_reset_run", 7'd20, 4'd1, 5'd1, 1'b0, ST_RUN);
        day_tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, FLD_NONE, 1'b0);
        check("after_reset_run", 7'd20, 4'd1, 5'd1, 1'b0, ST_RUN);

        // Asynchronous reset while in SET with a pending tick: nothing survives.
        load_date("load_22_08_20", 22, 8, 20);
        cycle(1'b0, 1'b1, FLD_NONE, 1'b0);
        cycle(1'b1, 1'b1, FLD_DAY, 1'b1);
        check("pre_reset_set", 7'd22, 4'd8, 5'd21, 1'b0, ST_SET);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_set", 7'd20, 4'd1, 5'd1, 1'b0, ST_RUN);
        set_en = 1'b0; inc = 1'b0; day_tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, FLD_NONE, 1'b0);
        cycle(1'b0, 1'b0, FLD_NONE, 1'b0);
        check("no_pending_after_reset", 7'd20, 4'd1, 5'd1, 1'b0, ST_RUN);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
